// File: rtl/encoder_pkg.sv
// Shared types and helpers for the pending-request encoder.
// Index width, state encoding and one-hot expansion.
package encoder_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(
    input logic [IDX_W-1:0] idx
  );
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/encoder_pend_prio_pick.sv
// Combinational priority picker over an 8-bit vector.
// PRIO_HIGH selects whether bit 7 or bit 0 wins.
module prio_pick
  import encoder_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic [N_REQ-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    idx = '0;
    any = |vec;
    if (PRIO_HIGH) begin
      for (int i = 0; i < N_REQ; i++)
        if (vec[i]) idx = IDX_W'(i);
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--)
        if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/encoder_pend.sv
// Sticky 8-to-3 pending encoder with valid/ready output.
// A bit clears only when its code is accepted; set beats clear.
module encoder_pend
  import encoder_pkg::*;
#(
  parameter bit PRIO_HIGH = 1'b1,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       out_ready,
  output logic       out_valid,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [7:0] pending,
  output logic       dropped
);

  state_t           state, state_n;
  logic [N_REQ-1:0] req_q;
  logic [N_REQ-1:0] ev, cap, clr;
  logic [N_REQ-1:0] pending_n;
  logic [IDX_W-1:0] code, code_n;
  logic [IDX_W-1:0] win;
  logic             win_any;
  logic             valid_n;
  logic             dropped_n;

  prio_pick #(
    .PRIO_HIGH (PRIO_HIGH)
  ) u_pick (
    .vec (pending),
    .idx (win),
    .any (win_any)
  );

  assign ev  = EDGE_MODE ? (req & ~req_q) : req;
  assign cap = enable ? ev : '0;

  always_comb begin
    state_n = state;
    valid_n = out_valid;
    code_n  = code;
    clr     = '0;
    unique case (state)
      IDLE: begin
        if (win_any) begin
          valid_n = 1'b1;
          code_n  = win;
          state_n = PRESENT;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          clr     = onehot(code);
          valid_n = 1'b0;
          code_n  = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Capture is OR'd in after the clear so a same-cycle event survives.
  assign pending_n = (pending & ~clr) | cap;
  assign dropped_n = |(cap & pending & ~clr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      pending   <= '0;
      out_valid <= 1'b0;
      code      <= '0;
      dropped   <= 1'b0;
    end else begin
      state     <= state_n;
      req_q     <= req;
      pending   <= pending_n;
      out_valid <= valid_n;
      code      <= code_n;
      dropped   <= dropped_n;
    end
  end

  assign {a, b, c} = code;

endmodule

// File: tb/tb_encoder_pend.sv
// Directed self-checking bench for encoder_pend.
// Three instances: high priority, low priority, level capture.
module tb_encoder_pend;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic       out_ready;

  logic       ov1, a1, b1, c1, dr1;
  logic [7:0] pd1;
  logic       ov0, a0, b0, c0, dr0;
  logic [7:0] pd0;
  logic       ov2, a2, b2, c2, dr2;
  logic [7:0] pd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  encoder_pend #(.PRIO_HIGH(1'b1), .EDGE_MODE(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .out_ready(out_ready), .out_valid(ov1),
    .a(a1), .b(b1), .c(c1), .pending(pd1), .dropped(dr1)
  );

  encoder_pend #(.PRIO_HIGH(1'b0), .EDGE_MODE(1'b1)) u_lo (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .out_ready(out_ready), .out_valid(ov0),
    .a(a0), .b(b0), .c(c0), .pending(pd0), .dropped(dr0)
  );

  encoder_pend #(.PRIO_HIGH(1'b1), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req),
    .out_ready(out_ready), .out_valid(ov2),
    .a(a2), .b(b2), .c(c2), .pending(pd2), .dropped(dr2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b1;
    req       = 8'h00;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({ov1, a1, b1, c1, dr1, pd1} !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_out: got %h want 0",
               {ov1, a1, b1, c1, dr1, pd1});
    end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    req = 8'h10;
    step();
    req = 8'h00;
    n_checks++;
    if (pd1 !== 8'h10 || ov1 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_T: pend %h v %b want 10 0", pd1, ov1);
    end
    step();
    n_checks++;
    if (ov1 !== 1'b1 || {a1, b1, c1} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_T1: v %b code %b want 1 100",
               ov1, {a1, b1, c1});
    end
    step();
    n_checks++;
    if (pd1 !== 8'h00 || ov1 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_T2: pend %h v %b want 00 0", pd1, ov1);
    end
  endtask

  task automatic test_priority();
    logic [2:0] hi [4] = '{3'd7, 3'd5, 3'd2, 3'd0};
    logic [2:0] lo [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
    do_reset();
    out_ready = 1'b1;
    req = 8'hA5;
    step();
    req = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      n_checks++;
      if (ov1 !== 1'b1 || {a1, b1, c1} !== hi[k]) begin
        n_fail++;
        $display("FAIL prio_hi[%0d]: v %b code %0d want 1 %0d",
                 k, ov1, {a1, b1, c1}, hi[k]);
      end
      n_checks++;
      if (ov0 !== 1'b1 || {a0, b0, c0} !== lo[k]) begin
        n_fail++;
        $display("FAIL prio_lo[%0d]: v %b code %0d want 1 %0d",
                 k, ov0, {a0, b0, c0}, lo[k]);
      end
      step();
      n_checks++;
      if (ov1 !== 1'b0 || ov0 !== 1'b0) begin
        n_fail++;
        $display("FAIL prio_bubble[%0d]: v %b %b want 0 0",
                 k, ov1, ov0);
      end
    end
    n_checks++;
    if (pd1 !== 8'h00 || pd0 !== 8'h00) begin
      n_fail++;
      $display("FAIL prio_end: pend %h %h want 00 00", pd1, pd0);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    for (int i = 0; i < 5; i++) begin
      req = (i == 2) ? 8'h80 : 8'h00;
      step();
      n_checks++;
      if (ov1 !== 1'b1 || {a1, b1, c1} !== 3'b011) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: v %b code %b want 1 011",
                 i, ov1, {a1, b1, c1});
      end
    end
    req = 8'h00;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (ov1 !== 1'b0 || pd1 !== 8'h80) begin
      n_fail++;
      $display("FAIL bp_accept: v %b pend %h want 0 80", ov1, pd1);
    end
    step();
    n_checks++;
    if (ov1 !== 1'b1 || {a1, b1, c1} !== 3'b111) begin
      n_fail++;
      $display("FAIL bp_next: v %b code %b want 1 111",
               ov1, {a1, b1, c1});
    end
  endtask

  task automatic test_set_clear();
    do_reset();
    req = 8'h08;
    step();
    req = 8'h00;
    step();
    out_ready = 1'b1;
    req = 8'h08;
    step();
    n_checks++;
    if (pd1 !== 8'h08 || ov1 !== 1'b0 || dr1 !== 1'b0) begin
      n_fail++;
      $display("FAIL sbc: pend %h v %b drop %b want 08 0 0",
               pd1, ov1, dr1);
    end
    req = 8'h00;
    out_ready = 1'b0;
    step();
    n_checks++;
    if (ov1 !== 1'b1 || {a1, b1, c1} !== 3'b011) begin
      n_fail++;
      $display("FAIL sbc_re: v %b code %b want 1 011",
               ov1, {a1, b1, c1});
    end
    req = 8'h08;
    step();
    req = 8'h00;
    n_checks++;
    if (dr1 !== 1'b1 || pd1 !== 8'h08) begin
      n_fail++;
      $display("FAIL drop_hi: drop %b pend %h want 1 08", dr1, pd1);
    end
    step();
    n_checks++;
    if (dr1 !== 1'b0 || pd1 !== 8'h08 || ov1 !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_lo: drop %b pend %h v %b want 0 08 1",
               dr1, pd1, ov1);
    end
  endtask

  task automatic test_enable();
    do_reset();
    enable = 1'b0;
    req = 8'hFF;
    step();
    n_checks++;
    if (pd1 !== 8'h00 || pd2 !== 8'h00) begin
      n_fail++;
      $display("FAIL en_off: pend %h lvl %h want 00 00", pd1, pd2);
    end
    enable = 1'b1;
    step();
    n_checks++;
    if (pd2 !== 8'hFF) begin
      n_fail++;
      $display("FAIL en_level: pend %h want ff", pd2);
    end
    step();
    step();
    n_checks++;
    if (pd1 !== 8'h00 || ov1 !== 1'b0) begin
      n_fail++;
      $display("FAIL en_held: pend %h v %b want 00 0", pd1, ov1);
    end
    req = 8'h00;
    step();
    req = 8'hFF;
    step();
    req = 8'h00;
    n_checks++;
    if (pd1 !== 8'hFF) begin
      n_fail++;
      $display("FAIL en_edge: pend %h want ff", pd1);
    end
  endtask

  task automatic test_full_drain();
    do_reset();
    out_ready = 1'b1;
    req = 8'hFF;
    step();
    req = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      step();
      n_checks++;
      if (ov1 !== 1'b1 || {a1, b1, c1} !== 3'(k)) begin
        n_fail++;
        $display("FAIL drain[%0d]: v %b code %0d want 1 %0d",
                 k, ov1, {a1, b1, c1}, k);
      end
      step();
    end
    n_checks++;
    if (pd1 !== 8'h00 || ov1 !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_end: pend %h v %b want 00 0", pd1, ov1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h0F;
    step();
    req = 8'h00;
    step();
    n_checks++;
    if (ov1 !== 1'b1 || pd1 !== 8'h0F || {a1, b1, c1} !== 3'b011) begin
      n_fail++;
      $display("FAIL rmid_pre: v %b pend %h code %b want 1 0f 011",
               ov1, pd1, {a1, b1, c1});
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++;
    if ({ov1, a1, b1, c1, dr1, pd1} !== 13'h0) begin
      n_fail++;
      $display("FAIL rmid_rst: got %h want 0",
               {ov1, a1, b1, c1, dr1, pd1});
    end
    step();
    step();
    n_checks++;
    if (ov1 !== 1'b0 || pd1 !== 8'h00) begin
      n_fail++;
      $display("FAIL rmid_quiet: v %b pend %h want 0 00", ov1, pd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: sim did not end, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    req       = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_priority();
    test_backpressure();
    test_set_clear();
    test_enable();
    test_full_drain();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_pend.md
Name: encoder_pend

Overview:
- 8-to-3 pending-request encoder, the inverse of the team's 3-to-8 enable decoder.
- Latches events on eight request lines into a sticky pending register.
- Presents the highest-priority pending index as a 3-bit code (a = MSB, b, c = LSB) using a valid/ready handshake.
- Clears each bit only when its code is accepted. Used as the interrupt/event source feeding the decoder-driven select logic.

Parameters:
- PRIO_HIGH, 1, 1 = req[7] has highest priority; 0 = req[0] has highest priority.
- EDGE_MODE, 1, 1 = capture rising edges of req; 0 = capture level (every cycle req is high).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- enable  input  1  capture enable; 0 blocks new captures only.
- req  input  8  request lines, synchronous to clk.
- out_ready  input  1  consumer accepts the presented code this cycle.
- out_valid  output  1  a, b, c hold a valid pending index.
- a  output  1  index bit 2.
- b  output  1  index bit 1.
- c  output  1  index bit 0.
- pending  output  8  current pending register, for debug and status.
- dropped  output  1  one-cycle pulse: an event hit a bit that was already pending.

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All state updates on the rising edge of clk.
- Reset: while rst_n is low at an edge, all outputs and state go to 0.
  - Cleared: pending, req_q, out_valid, a, b, c, dropped; state = IDLE.
  - Applies mid-handshake too; an unaccepted code is discarded.
- Event detection:
  - ev = req & ~req_q when EDGE_MODE = 1; ev = req when EDGE_MODE = 0.
  - req_q is req registered every cycle, regardless of enable.
  - cap = enable ? ev : 8'h00.
- Pending update: pending_next = (pending & ~clr) | cap.
  - clr is a one-hot mask of the accepted index, nonzero only on an accepted handshake.
  - Set beats clear: a capture on the bit being cleared in the same cycle leaves it pending.
- dropped: registered pulse, high for one cycle after any edge where (cap & pending & ~clr) != 0. Pending is unchanged in that case.
- State machine:
  - IDLE: out_valid = 0; a, b, c = 0.
    - If the registered pending is nonzero: load a, b, c with the priority winner of pending, set out_valid = 1, go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT: a, b, c and out_valid are held stable while out_ready = 0.
    - When out_ready = 1: clr = onehot(index), out_valid = 0, go to IDLE.
    - This gives one bubble cycle between consecutive grants.
  - Captures arriving in PRESENT do not change the presented code, even if higher priority. They are considered at the next IDLE evaluation.
- Latency:
  - req rises before edge T, so pending is set at edge T.
  - out_valid is high after edge T+1: two cycles from req to valid when the FSM is in IDLE.
- Throughput: at most one accepted code every 2 cycles.
- enable = 0:
  - Pending bits are retained and continue to be presented and cleared.
  - req_q still tracks req, so an edge occurring while enable = 0 is lost. It is not deferred.
- out_ready while out_valid = 0 is ignored.
- All 8 bits pending with PRIO_HIGH = 1 are served in order 7, 6, ..., 0 in 16 cycles (no new events).

Decomposition:
- Package encoder_pkg:
  - N_REQ = 8, IDX_W = 3.
  - State enum {IDLE, PRESENT}.
  - Function onehot(idx) returning 8 bits.
- Sub-module prio_pick:
  - Purely combinational. Inputs: vec[7:0] and the PRIO_HIGH parameter.
  - Outputs: idx[2:0] and any.
  - Instantiated once in encoder_pend; reusable elsewhere.

Test Plan:
- Reset/basic:
  - Stimulus: rst_n = 0 for 2 cycles, then 1; enable = 1; pulse req = 8'h10 for 1 cycle; out_ready = 1.
  - Response: pending = 8'h10 after edge T; out_valid = 1 with {a,b,c} = 3'b100 after edge T+1; pending = 0 and out_valid = 0 after edge T+2.
- Priority and order:
  - Stimulus: PRIO_HIGH = 1; single pulse req = 8'hA5; out_ready held 1.
  - Response: codes 7, 5, 2, 0 in that order, each separated by one out_valid = 0 cycle; pending ends at 8'h00.
  - Repeat with PRIO_HIGH = 0: order 0, 2, 5, 7.
- Backpressure:
  - Stimulus: req pulse 8'h08; out_ready = 0 for 5 cycles; during the stall, pulse req 8'h80.
  - Response: {a,b,c} stays 3'b011 with out_valid = 1 throughout the stall; after acceptance, the next code is 3'b111.
- Set-beats-clear and dropped:
  - Set-beats-clear: bit 3 presented; pulse req[3] again in the accept cycle (out_ready = 1) → pending[3] stays 1 and code 3 is re-presented; dropped = 0.
  - dropped: pulse req[3] while it is pending and not being accepted → dropped = 1 for exactly 1 cycle; pending unchanged.
- Enable gating:
  - Stimulus: enable = 0; pulse req = 8'hFF; then enable = 1 with req held high (EDGE_MODE = 1).
  - Response: pending = 0 and out_valid never rises, because no new edge occurs. Then drop req and re-raise it → 8'hFF is captured.
- Reset mid-operation:
  - Stimulus: pending = 8'h0F with out_valid = 1; drive rst_n = 0 for 1 cycle.
  - Response: after that edge, pending = 0, out_valid = 0, {a,b,c} = 0, dropped = 0; no output activity until the next req edge.
